// File: rtl/awgn_pkg.sv
// Shared constants for the AWGN generator datapath.
// Holds the widths, the zero-input count and the step lists for the normalizer stages.
package awgn_pkg;

    localparam int DATA_W    = 48;
    localparam int CNT_W     = 6;
    localparam int STEP_W    = 8;
    localparam int NUM_STEPS = 3;

    localparam logic [CNT_W-1:0] ZERO_CNT = 6'd48;

    // Step lists are packed with the first step applied in the most significant field
    localparam logic [NUM_STEPS*STEP_W-1:0] COARSE_STEPS = {8'd32, 8'd16, 8'd8};
    localparam logic [NUM_STEPS*STEP_W-1:0] FINE_STEPS   = {8'd4, 8'd2, 8'd1};

endpackage

// File: rtl/norm_stage_left.sv
// Combinational slice of the left normalizer: applies a list of conditional left shifts.
// Each step shifts only when the top 'step' bits of the running word are all zero.
module norm_stage_left
    import awgn_pkg::*;
#(
    parameter int                      NUM   = NUM_STEPS,
    parameter logic [NUM*STEP_W-1:0]   STEPS = COARSE_STEPS
) (
    input  logic [DATA_W-1:0] word,
    input  logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] norm_word,
    output logic [CNT_W-1:0]  norm_count
);

    always_comb begin
        norm_word  = word;
        norm_count = count;
        for (int i = 0; i < NUM; i++) begin
            if ((norm_word >> (DATA_W - int'(STEPS[(NUM-1-i)*STEP_W +: STEP_W]))) == '0) begin
                norm_word  = norm_word << STEPS[(NUM-1-i)*STEP_W +: STEP_W];
                norm_count = norm_count + CNT_W'(STEPS[(NUM-1-i)*STEP_W +: STEP_W]);
            end
        end
    end

endmodule

// File: rtl/normalizer_48_left.sv
// Two-stage pipelined 48-bit left normalizer with valid/ready on both sides.
// Stage 1 does the 32/16/8 coarse shifts, stage 2 the 4/2/1 fine shifts into the outputs.
module normalizer_48_left
    import awgn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] num,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] shifted,
    output logic [CNT_W-1:0]  shift_count,
    output logic              is_zero
);

    logic              s1_valid;
    logic              s1_ready;
    logic              s2_ready;
    logic [DATA_W-1:0] s1_word;
    logic [CNT_W-1:0]  s1_count;
    logic              s1_zero;
    logic [DATA_W-1:0] coarse_word;
    logic [CNT_W-1:0]  coarse_count;
    logic [DATA_W-1:0] fine_word;
    logic [CNT_W-1:0]  fine_count;

    norm_stage_left #(
        .NUM   (NUM_STEPS),
        .STEPS (COARSE_STEPS)
    ) u_coarse (
        .word       (num),
        .count      ('0),
        .norm_word  (coarse_word),
        .norm_count (coarse_count)
    );

    norm_stage_left #(
        .NUM   (NUM_STEPS),
        .STEPS (FINE_STEPS)
    ) u_fine (
        .word       (s1_word),
        .count      (s1_count),
        .norm_word  (fine_word),
        .norm_count (fine_count)
    );

    // A stage may load when it is empty or its contents move on this same cycle
    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && s1_ready) begin
            s1_word  <= coarse_word;
            s1_count <= coarse_count;
            s1_zero  <= (num == '0);
        end
    end

    // The fine stage of an all-zero word would report 63, so the zero flag forces 48
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            shifted     <= '0;
            shift_count <= '0;
            is_zero     <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                shifted     <= s1_zero ? '0 : fine_word;
                shift_count <= s1_zero ? ZERO_CNT : fine_count;
                is_zero     <= s1_zero;
            end
        end
    end

endmodule

// File: tb/tb_normalizer_48_left.sv
// Self-checking bench for normalizer_48_left: directed table, stall, reset and random runs.
// A bit-scan reference model and an in-order scoreboard check every emitted word.
module tb_normalizer_48_left;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] num;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] shifted;
    logic [5:0]  shift_count;
    logic        is_zero;

    typedef struct {
        logic [47:0] s;
        logic [5:0]  c;
        logic        z;
    } res_t;

    typedef struct {
        logic [47:0] num;
        logic [47:0] s;
        logic [5:0]  c;
        logic        z;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   accepted = 0;
    int   emitted = 0;
    res_t exp_q[$];
    vec_t vecs[10];
    logic prev_pending = 1'b0;

    always #5 clk = ~clk;

    normalizer_48_left dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num         (num),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .shifted     (shifted),
        .shift_count (shift_count),
        .is_zero     (is_zero)
    );

    function automatic res_t model(input logic [47:0] n);
        res_t r;
        bit   found = 1'b0;
        r.s = '0;
        r.c = 6'd48;
        r.z = (n == '0);
        for (int b = 47; b >= 0; b--) begin
            if (!found && n[b]) begin
                found = 1'b1;
                r.c   = 6'(47 - b);
                r.s   = n << (47 - b);
            end
        end
        return r;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_output(input string name, input logic [47:0] s, input logic [5:0] c,
                                input logic z);
        check_val({name, ".out_valid"}, 64'(out_valid), 64'd1);
        check_val({name, ".shifted"}, 64'(shifted), 64'(s));
        check_val({name, ".shift_count"}, 64'(shift_count), 64'(c));
        check_val({name, ".is_zero"}, 64'(is_zero), 64'(z));
    endtask

    // Called at posedge+1; the word is taken at the next edge (pipe assumed ready)
    task automatic apply_stimulus(input logic [47:0] v);
        in_valid = 1'b1;
        num      = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num      = '0;
    endtask

    function automatic logic [47:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[47:0] >> $urandom_range(0, 48);
    endfunction

    // Scoreboard: handshakes are judged at the falling edge, where all inputs are stable
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_pending <= 1'b0;
        end else begin
            assert (!(prev_pending && !in_valid))
                else $error("[TB] in_valid withdrawn before acceptance");
            if (out_valid && out_ready) begin
                emitted++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL scoreboard: unexpected word %h count %0d", shifted,
                             shift_count);
                end else begin
                    check_val("sb.shifted", 64'(shifted), 64'(exp_q[0].s));
                    check_val("sb.shift_count", 64'(shift_count), 64'(exp_q[0].c));
                    check_val("sb.is_zero", 64'(is_zero), 64'(exp_q[0].z));
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                accepted++;
                exp_q.push_back(model(num));
            end
            prev_pending <= in_valid && !in_ready;
        end
    end

    initial begin
        logic [47:0] w[3];
        res_t        r;
        logic        acc;
        int          sent;
        int          cycles;

        vecs[0] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 6'd0,  1'b0};
        vecs[1] = '{48'h0000_0000_0001, 48'h8000_0000_0000, 6'd47, 1'b0};
        vecs[2] = '{48'h0000_1234_5678, 48'h91A2_B3C0_0000, 6'd19, 1'b0};
        vecs[3] = '{48'h0000_0000_0000, 48'h0000_0000_0000, 6'd48, 1'b1};
        vecs[4] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 6'd0,  1'b0};
        vecs[5] = '{48'h0000_0000_8000, 48'h8000_0000_0000, 6'd32, 1'b0};
        vecs[6] = '{48'h0001_0000_0000, 48'h8000_0000_0000, 6'd15, 1'b0};
        vecs[7] = '{48'h0000_0000_0003, 48'hC000_0000_0000, 6'd46, 1'b0};
        vecs[8] = '{48'h4000_0000_0001, 48'h8000_0000_0002, 6'd1,  1'b0};
        vecs[9] = '{48'h0F0F_0000_0000, 48'hF0F0_0000_0000, 6'd4,  1'b0};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        num       = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.out_valid", 64'(out_valid), 64'd0);
        check_val("reset.shifted", 64'(shifted), 64'd0);
        check_val("reset.shift_count", 64'(shift_count), 64'd0);
        check_val("reset.is_zero", 64'(is_zero), 64'd0);
        rst_n = 1'b1;
        #3;
        check_val("reset.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed table");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].num);
            check_val($sformatf("vec%0d.latency1", i), 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].z);
        end
        @(posedge clk);
        #1;

        $display("[TB] stall sequence");
        w[0] = 48'h0000_00F0_0000;
        w[1] = 48'h0300_0000_0000;
        w[2] = 48'h0000_0000_0000;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        num       = w[0];
        @(posedge clk);
        #1;
        num = w[1];
        @(posedge clk);
        #1;
        num = w[2];
        r = model(w[0]);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("stall%0d.in_ready", k), 64'(in_ready), 64'd0);
            check_output($sformatf("stall%0d", k), r.s, r.c, r.z);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check_val("release.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num      = '0;
        r = model(w[1]);
        check_output("drain1", r.s, r.c, r.z);
        @(posedge clk);
        #1;
        check_output("drain2", 48'h0, 6'd48, 1'b1);
        @(posedge clk);
        #1;
        check_val("drain.empty", 64'(out_valid), 64'd0);

        $display("[TB] reset mid-stream");
        in_valid = 1'b1;
        num      = 48'h0000_0000_0ABC;
        @(posedge clk);
        #1;
        num = 48'h1234_0000_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num      = '0;
        check_val("midrst.before", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst.async", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("midrst.stale%0d", k), 64'(out_valid), 64'd0);
        end
        accepted = 0;
        emitted  = 0;

        $display("[TB] random run");
        acc    = 1'b0;
        sent   = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 60000) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                num      = rand_word();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sent < 10000) begin
            total++;
            bad++;
            $display("[TB] FAIL random.budget: sent %0d, required 10000", sent);
        end
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_val("random.drained", 64'(exp_q.size()), 64'd0);
        check_val("random.count", 64'(emitted), 64'(accepted));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
